// File: rtl/core_inst_seq.sv
// core_inst_seq: instruction sequencer for the 8x8 weight-stationary core.
// For every kernel offset kij it streams weights into L0 and the array, streams
// activations through L0 into the array, then drains the OFIFO while doing a
// psum read-modify-write into pmem. The host pulses start and waits for done.
// Optional feature: define SEQ_PERF_CNT_EN to add the cyc_cnt / stall_cnt
// performance counters. The default build (macro undefined) has neither port.
module core_inst_seq #(
  parameter int          col      = 8,
  parameter int          LEN_KIJ  = 9,
  parameter int          LEN_NIJ  = 36,
  parameter int          LEN_ONIJ = 16,
  parameter int          SETTLE   = 16,
  parameter logic [10:0] W_BASE   = 11'd1024,
  parameter logic [10:0] X_BASE   = 11'd0,
  parameter logic [10:0] P_BASE   = 11'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij_idx
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] stall_cnt
`endif
);

  // Field layout of the core instruction bus, MSB first.
  typedef struct packed {
    logic        acc;
    logic        cen_pmem;
    logic        wen_pmem;
    logic [10:0] a_pmem;
    logic        cen_xmem;
    logic        wen_xmem;
    logic [10:0] a_xmem;
    logic        ofifo_rd;
    logic        ififo_wr;
    logic        ififo_rd;
    logic        l0_rd;
    logic        l0_wr;
    logic        execute;
    logic        load;
  } inst_t;

  // Both SRAMs deselected and in read mode; everything else quiet.
  localparam logic [33:0] NOP_INST = {1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0};

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] W_RD     = 4'd1;
  localparam logic [3:0] W_LOAD   = 4'd2;
  localparam logic [3:0] W_SETTLE = 4'd3;
  localparam logic [3:0] X_RD     = 4'd4;
  localparam logic [3:0] X_EXEC   = 4'd5;
  localparam logic [3:0] ACC_RD   = 4'd6;
  localparam logic [3:0] ACC_WR   = 4'd7;
  localparam logic [3:0] FLUSH    = 4'd8;
  localparam logic [3:0] DONE     = 4'd9;

  typedef logic [15:0] cnt_t;
  localparam cnt_t        COL_N       = cnt_t'(col);
  localparam cnt_t        COL_LAST    = cnt_t'(col - 1);
  localparam cnt_t        SETTLE_LAST = cnt_t'(SETTLE - 1);
  localparam cnt_t        NIJ_N       = cnt_t'(LEN_NIJ);
  localparam cnt_t        NIJ_LAST    = cnt_t'(LEN_NIJ - 1);
  localparam cnt_t        ONIJ_LAST   = cnt_t'(LEN_ONIJ - 1);
  localparam cnt_t        FLUSH_N     = cnt_t'(LEN_NIJ - LEN_ONIJ);
  localparam cnt_t        FLUSH_LAST  = cnt_t'(LEN_NIJ - LEN_ONIJ - 1);
  localparam logic [3:0]  KIJ_LAST    = 4'(LEN_KIJ - 1);
  localparam logic [10:0] COL_A       = 11'(col);

  logic [3:0] state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  cnt_t       o_q, o_d;
  logic [3:0] kij_q, kij_d;
  logic       busy_d, done_d;
  inst_t      inst_d;
  logic       start_ok;

  // A start is honoured only from a genuinely idle sequencer (not the done cycle).
  assign start_ok = (state_q == IDLE) && !busy && start;
  assign kij_idx  = kij_q;

  // Next-state and next-instruction decode; the instruction register below
  // presents this decision on the following cycle.
  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    o_d     = o_q;
    kij_d   = kij_q;
    busy_d  = busy;
    done_d  = 1'b0;
    inst_d  = NOP_INST;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (start_ok) begin
          state_d = W_RD;
          kij_d   = '0;
          busy_d  = 1'b1;
        end
      end
      W_RD: begin
        if (cnt_q < COL_N) begin
          inst_d.cen_xmem = 1'b0;
          inst_d.a_xmem   = W_BASE + 11'(kij_q) * COL_A + cnt_q[10:0];
        end
        // Read data arrives one cycle after the address, so the L0 write trails.
        if (cnt_q != '0) inst_d.l0_wr = 1'b1;
        if (cnt_q == COL_N) begin
          state_d = W_LOAD;
          cnt_d   = '0;
        end
      end
      W_LOAD: begin
        inst_d.l0_rd = 1'b1;
        inst_d.load  = 1'b1;
        if (cnt_q == COL_LAST) begin
          state_d = W_SETTLE;
          cnt_d   = '0;
        end
      end
      W_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = X_RD;
          cnt_d   = '0;
        end
      end
      X_RD: begin
        if (cnt_q < NIJ_N) begin
          inst_d.cen_xmem = 1'b0;
          inst_d.a_xmem   = X_BASE + cnt_q[10:0];
        end
        if (cnt_q != '0) inst_d.l0_wr = 1'b1;
        if (cnt_q == NIJ_N) begin
          state_d = X_EXEC;
          cnt_d   = '0;
        end
      end
      X_EXEC: begin
        inst_d.l0_rd   = 1'b1;
        inst_d.execute = 1'b1;
        if (cnt_q == NIJ_LAST) begin
          state_d = ACC_RD;
          cnt_d   = '0;
          o_d     = '0;
        end
      end
      ACC_RD: begin
        cnt_d = '0;
        // Stall with a NOP until the OFIFO has a full row to hand over.
        if (ofifo_valid) begin
          inst_d.ofifo_rd = 1'b1;
          inst_d.cen_pmem = 1'b0;
          inst_d.a_pmem   = P_BASE + o_q[10:0];
          state_d         = ACC_WR;
        end
      end
      ACC_WR: begin
        cnt_d           = '0;
        inst_d.cen_pmem = 1'b0;
        inst_d.wen_pmem = 1'b0;
        inst_d.a_pmem   = P_BASE + o_q[10:0];
        // First kernel offset overwrites pmem, later ones accumulate into it.
        inst_d.acc      = (kij_q != '0);
        if (o_q != ONIJ_LAST) begin
          o_d     = o_q + 1'b1;
          state_d = ACC_RD;
        end else if (FLUSH_N != '0) begin
          state_d = FLUSH;
        end else if (kij_q == KIJ_LAST) begin
          state_d = DONE;
        end else begin
          kij_d   = kij_q + 1'b1;
          state_d = W_RD;
        end
      end
      FLUSH: begin
        // Discard the OFIFO rows that do not map to an output psum.
        cnt_d = cnt_q;
        if (ofifo_valid) begin
          inst_d.ofifo_rd = 1'b1;
          cnt_d           = cnt_q + 1'b1;
          if (cnt_q == FLUSH_LAST) begin
            cnt_d = '0;
            if (kij_q == KIJ_LAST) begin
              state_d = DONE;
            end else begin
              kij_d   = kij_q + 1'b1;
              state_d = W_RD;
            end
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters and the registered instruction/handshake outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and they all update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      o_q     <= '0;
      kij_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      inst    <= NOP_INST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      kij_q   <= kij_d;
      busy    <= busy_d;
      done    <= done_d;
      inst    <= inst_d;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  // Run-length and OFIFO-starvation counters; cleared per run, held afterwards.
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (busy) cyc_cnt <= cyc_cnt + 32'd1;
      if ((state_q == ACC_RD || state_q == FLUSH) && !ofifo_valid)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_inst_seq.sv
// tb_core_inst_seq: self-checking bench for core_inst_seq. The expected
// instruction stream of a whole run is built from the phase rules as a queue;
// OFIFO-dependent entries are held back (a NOP is expected instead) whenever
// ofifo_valid was low at the edge that issued them.
module tb_core_inst_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij_idx;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cyc_cnt;
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  core_inst_seq u_dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done),
    .kij_idx     (kij_idx)
`ifdef SEQ_PERF_CNT_EN
    ,
    .cyc_cnt     (cyc_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  localparam int N_KIJ = 9;
  localparam int N_COL = 8;
  localparam int N_NIJ = 36;
  localparam int N_ONIJ = 16;
  localparam int N_SETTLE = 16;

  typedef enum {E_NOP, E_WRD, E_LOAD, E_XRD, E_EXEC, E_ACCRD, E_ACCWR, E_FLUSH} kind_e;
  typedef struct {
    logic [33:0] inst;
    kind_e       kind;
    bit          done;
    int          kij;
    int          o;
  } entry_t;

  entry_t exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [33:0] make_inst(input bit acc, input bit cenp, input bit wenp,
                                            input int ap, input bit cenx, input bit wenx,
                                            input int ax, input bit ofrd, input bit l0rd,
                                            input bit l0wr, input bit exe, input bit ld);
    logic [10:0] a_p;
    logic [10:0] a_x;
    a_p = ap[10:0];
    a_x = ax[10:0];
    return {acc, cenp, wenp, a_p, cenx, wenx, a_x, ofrd, 1'b0, 1'b0, l0rd, l0wr, exe, ld};
  endfunction

  function automatic logic [33:0] nop();
    return make_inst(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic void push(input logic [33:0] i, input kind_e k, input int kj,
                               input int o, input bit d);
    exp_q.push_back('{inst: i, kind: k, done: d, kij: kj, o: o});
  endfunction

  // Whole-run expected stream: one NOP on the accept edge, the per-kij phases,
  // then the done NOP.
  task automatic build_stream();
    exp_q.delete();
    push(nop(), E_NOP, 0, 0, 0);
    for (int k = 0; k < N_KIJ; k++) begin
      for (int i = 0; i <= N_COL; i++)
        push(make_inst(0, 1, 1, 0, (i < N_COL) ? 1'b0 : 1'b1, 1,
                       (i < N_COL) ? 1024 + k * N_COL + i : 0, 0, 0, i >= 1, 0, 0),
             E_WRD, k, i, 0);
      for (int i = 0; i < N_COL; i++)
        push(make_inst(0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 0, 1), E_LOAD, k, i, 0);
      for (int i = 0; i < N_SETTLE; i++)
        push(nop(), E_NOP, k, i, 0);
      for (int i = 0; i <= N_NIJ; i++)
        push(make_inst(0, 1, 1, 0, (i < N_NIJ) ? 1'b0 : 1'b1, 1,
                       (i < N_NIJ) ? i : 0, 0, 0, i >= 1, 0, 0),
             E_XRD, k, i, 0);
      for (int i = 0; i < N_NIJ; i++)
        push(make_inst(0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 1, 0), E_EXEC, k, i, 0);
      for (int o = 0; o < N_ONIJ; o++) begin
        push(make_inst(0, 0, 1, o, 1, 1, 0, 1, 0, 0, 0, 0), E_ACCRD, k, o, 0);
        push(make_inst(k != 0, 0, 0, o, 1, 1, 0, 0, 0, 0, 0, 0), E_ACCWR, k, o, 0);
      end
      for (int i = 0; i < N_NIJ - N_ONIJ; i++)
        push(make_inst(0, 1, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0), E_FLUSH, k, i, 0);
    end
    push(nop(), E_NOP, N_KIJ - 1, 0, 1);
  endtask

  // Walks the expected stream one cycle at a time. Caller enters on a negedge
  // with start already raised. hold_o >= 0 forces ofifo_valid low for 5 edges
  // while the kij 0 read of that psum index is pending.
  task automatic run_stream(input bit rand_valid, input int hold_o, input bit stop_at_exec,
                            output int busy_cycles, output int stalls);
    int     hold_left;
    int     cyc;
    bit     prev_valid;
    bit     popped;
    entry_t e;
    logic [33:0] ei;
    bit     ed;
    hold_left   = (hold_o >= 0) ? 5 : 0;
    cyc         = 0;
    busy_cycles = 0;
    stalls      = 0;
    prev_valid  = ofifo_valid;
    while (exp_q.size() != 0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if ((exp_q[0].kind == E_ACCRD || exp_q[0].kind == E_FLUSH) && !prev_valid) begin
        popped = 1'b0;
        ei     = nop();
        ed     = 1'b0;
        stalls++;
      end else begin
        popped = 1'b1;
        e      = exp_q.pop_front();
        ei     = e.inst;
        ed     = e.done;
      end
      check("inst", inst, ei);
      check("busy", busy, 1);
      check("done", done, ed);
      if (popped && e.kind == E_WRD && e.o == 0) check("kij_idx", kij_idx, e.kij);
      if (busy) busy_cycles++;
      if (stop_at_exec && popped && e.kind == E_EXEC) return;
      // A start mid-run must be ignored.
      if (rand_valid && cyc == 40) start = 1'b1;
      if (hold_left > 0 && exp_q.size() != 0 && exp_q[0].kind == E_ACCRD &&
          exp_q[0].kij == 0 && exp_q[0].o == hold_o) begin
        ofifo_valid = 1'b0;
        hold_left--;
      end else if (rand_valid) begin
        ofifo_valid = ($urandom_range(0, 2) != 0);
      end else begin
        ofifo_valid = 1'b1;
      end
      prev_valid = ofifo_valid;
    end
    check("stream_left", exp_q.size(), 0);
    ofifo_valid = 1'b1;
    @(negedge clk);
    check("post_inst", inst, nop());
    check("post_busy", busy, 0);
    check("post_done", done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected a finished run");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int st;
    reset       = 1'b1;
    start       = 1'b0;
    ofifo_valid = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset.
    repeat (10) begin
      @(negedge clk);
      check("idle_inst", inst, nop());
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_kij", kij_idx, 0);
    end

    // Start coincident with reset: reset wins.
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_start_busy", busy, 0);
      check("rst_start_inst", inst, nop());
    end

    // Full run with a 5-cycle valid-low hold at psum index 3 of kij 0.
    build_stream();
    start = 1'b1;
    run_stream(1'b0, 3, 1'b0, bc, st);
`ifdef SEQ_PERF_CNT_EN
    check("hold_stall_cnt", stall_cnt, 5);
    check("hold_cyc_cnt", cyc_cnt, bc);
    repeat (3) @(negedge clk);
    check("hold_cyc_cnt_held", cyc_cnt, bc);
`endif

    // Full run with random ofifo_valid and a start pulse while busy.
    build_stream();
    start = 1'b1;
    run_stream(1'b1, -1, 1'b0, bc, st);
`ifdef SEQ_PERF_CNT_EN
    check("rand_stall_cnt", stall_cnt, st);
    check("rand_cyc_cnt", cyc_cnt, bc);
`endif

    // Reset during X_EXEC, then restart from kij 0.
    build_stream();
    start = 1'b1;
    run_stream(1'b0, -1, 1'b1, bc, st);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_inst", inst, nop());
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_kij", kij_idx, 0);
`ifdef SEQ_PERF_CNT_EN
    check("midrst_cyc_cnt", cyc_cnt, 0);
`endif
    reset = 1'b0;
    build_stream();
    start = 1'b1;
    run_stream(1'b1, -1, 1'b0, bc, st);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
